pwm_channel_scheduler: RTL and testbench

PWM_CHANNEL_SCHEDULER -- requirements
Module: pwm_channel_scheduler

---
 rtl/pwm_channel_scheduler_if.sv | 25 ++
 rtl/pwm_channel_scheduler.sv | 149 ++++++++++++++
 tb/tb_pwm_channel_scheduler.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/pwm_channel_scheduler_if.sv
// Scheduler bus: control inputs, PWM lines, result outputs.
// master drives ena/pwm_in/ch_enable; slave returns state and results.
interface pwm_channel_scheduler_if;
  logic        ena;
  logic [7:0]  pwm_in;
  logic [7:0]  ch_enable;
  logic [2:0]  sel_ch;
  logic        busy;
  logic        result_valid;
  logic [2:0]  result_ch;
  logic [10:0] result_width;
  logic [1:0]  result_class;

  modport master (
    output ena, pwm_in, ch_enable,
    input  sel_ch, busy, result_valid,
    input  result_ch, result_width, result_class
  );

  modport slave (
    input  ena, pwm_in, ch_enable,
    output sel_ch, busy, result_valid,
    output result_ch, result_width, result_class
  );
endinterface

// File: rtl/pwm_channel_scheduler.sv
// Round-robin high-width meter for eight PWM channels, one counter.
// Ports: clk, rst (async high), bus (slave) carrying control/results.
module pwm_channel_scheduler #(
  parameter int MAX_COUNTER_VALUE  = 2000,
  parameter int HIGH_COUNTER_VALUE = 1900,
  parameter int LOW_COUNTER_VALUE  = 1100
) (
  input  logic clk,
  input  logic rst,
  pwm_channel_scheduler_if.slave bus
);

  localparam logic [10:0] L_MAX  = 11'(MAX_COUNTER_VALUE);
  localparam logic [10:0] L_HIGH = 11'(HIGH_COUNTER_VALUE);
  localparam logic [10:0] L_LOW  = 11'(LOW_COUNTER_VALUE);

  typedef enum logic [2:0] {
    IDLE, SELECT, WAIT_LOW, WAIT_RISE, MEASURE, REPORT
  } state_t;

  state_t      r_state;
  logic [7:0]  r_sync1, r_sync2;
  logic [10:0] r_cnt;
  logic [2:0]  r_sel, r_last;
  logic        r_busy, r_valid;
  logic [2:0]  r_res_ch;
  logic [10:0] r_res_w;
  logic [1:0]  r_res_cls;

  logic        w_bit, w_any, w_tmo;
  logic [2:0]  w_pick, w_cand;

  assign w_bit = r_sync2[r_sel];
  assign w_any = |bus.ch_enable;
  assign w_tmo = (r_cnt == L_MAX);

  // Lowest offset from last_ch+1 wins, so scan offsets downward.
  always_comb begin
    w_pick = r_last;
    w_cand = r_last;
    for (int i = 8; i >= 1; i--) begin
      w_cand = r_last + 3'(i);
      if (bus.ch_enable[w_cand]) w_pick = w_cand;
    end
  end

  function automatic logic [1:0] classify(
    input logic [10:0] w
  );
    if (w > L_HIGH)     return 2'b10;
    else if (w < L_LOW) return 2'b00;
    else                return 2'b01;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_sync1   <= '0;
      r_sync2   <= '0;
      r_cnt     <= '0;
      r_sel     <= '0;
      r_last    <= 3'd7;
      r_busy    <= 1'b0;
      r_valid   <= 1'b0;
      r_res_ch  <= '0;
      r_res_w   <= '0;
      r_res_cls <= 2'b00;
    end else begin
      r_sync1 <= bus.pwm_in;
      r_sync2 <= r_sync1;
      r_valid <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (bus.ena && w_any) begin
            r_state <= SELECT;
            r_busy  <= 1'b1;
          end
        end
        SELECT: begin
          if (!bus.ena || !w_any) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_sel   <= w_pick;
            r_cnt   <= '0;
            r_state <= WAIT_LOW;
          end
        end
        WAIT_LOW, WAIT_RISE, MEASURE: begin
          if (!bus.ena) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end else if (w_tmo) begin
            r_state   <= REPORT;
            r_valid   <= 1'b1;
            r_res_ch  <= r_sel;
            r_res_w   <= L_MAX;
            r_res_cls <= 2'b11;
          end else if (r_state == WAIT_LOW) begin
            if (!w_bit) begin
              r_state <= WAIT_RISE;
              r_cnt   <= '0;
            end else begin
              r_cnt <= r_cnt + 11'd1;
            end
          end else if (r_state == WAIT_RISE) begin
            if (w_bit) begin
              r_state <= MEASURE;
              r_cnt   <= 11'd1;
            end else begin
              r_cnt <= r_cnt + 11'd1;
            end
          end else begin
            if (!w_bit) begin
              r_state   <= REPORT;
              r_valid   <= 1'b1;
              r_res_ch  <= r_sel;
              r_res_w   <= r_cnt;
              r_res_cls <= classify(r_cnt);
            end else begin
              r_cnt <= r_cnt + 11'd1;
            end
          end
        end
        REPORT: begin
          r_last <= r_sel;
          if (bus.ena) begin
            r_state <= SELECT;
          end else begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.sel_ch       = r_sel;
  assign bus.busy         = r_busy;
  assign bus.result_valid = r_valid;
  assign bus.result_ch    = r_res_ch;
  assign bus.result_width = r_res_w;
  assign bus.result_class = r_res_cls;

endmodule

// File: tb/tb_pwm_channel_scheduler.sv
// Scoreboard bench for pwm_channel_scheduler.
// Directed pulses push expected results; a monitor pops and compares.
module tb_pwm_channel_scheduler;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pwm_channel_scheduler_if bus ();

  pwm_channel_scheduler #(
    .MAX_COUNTER_VALUE (2000),
    .HIGH_COUNTER_VALUE(1900),
    .LOW_COUNTER_VALUE (1100)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  typedef struct {
    logic [2:0]  ch;
    logic [10:0] w;
    logic [1:0]  c;
  } exp_t;

  exp_t q[$];
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string nm, int act, int req);
    n_total++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d want %0d", nm, act, req);
  endtask

  task automatic expect_res(int ch, int w, int c);
    exp_t e;
    e.ch = 3'(ch);
    e.w  = 11'(w);
    e.c  = 2'(c);
    q.push_back(e);
  endtask

  task automatic pulse(logic [7:0] m, int hi, int lo);
    bus.pwm_in = m;
    repeat (hi) tick();
    bus.pwm_in = 8'h00;
    repeat (lo) tick();
  endtask

  task automatic drain(int max);
    int n = 0;
    while (q.size() != 0 && n < max) begin
      tick();
      n++;
    end
    if (q.size() != 0) begin
      $display("FAIL drain: %0d results missing after %0d cycles",
               q.size(), max);
      n_total += q.size();
      q.delete();
    end
  endtask

  task automatic go_idle();
    bus.ena = 1'b0;
    repeat (3) tick();
  endtask

  task automatic chk_reset_outs(string tag);
    chk({tag, " sel_ch"}, int'(bus.sel_ch), 0);
    chk({tag, " busy"}, int'(bus.busy), 0);
    chk({tag, " valid"}, int'(bus.result_valid), 0);
    chk({tag, " res_ch"}, int'(bus.result_ch), 0);
    chk({tag, " res_w"}, int'(bus.result_width), 0);
    chk({tag, " res_cls"}, int'(bus.result_class), 0);
  endtask

  // Monitor: compares every published result against the queue head.
  initial begin
    logic prev;
    exp_t e;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev = 1'b0;
      end else begin
        if (bus.result_valid && prev) begin
          n_total++;
          $display("FAIL pulse_len: valid high %0d cycles want 1", 2);
        end
        if (bus.result_valid && !prev) begin
          if (q.size() == 0) begin
            n_total++;
            $display("FAIL unexpected: ch %0d w %0d cls %0d want none",
                     bus.result_ch, bus.result_width,
                     bus.result_class);
          end else begin
            e = q.pop_front();
            n_total++;
            if (bus.result_ch == e.ch && bus.result_width == e.w &&
                bus.result_class == e.c) begin
              n_pass++;
            end else begin
              $display("FAIL result: got ch%0d w%0d c%0d want ch%0d w%0d c%0d",
                       bus.result_ch, bus.result_width,
                       bus.result_class, e.ch, e.w, e.c);
            end
          end
        end
        prev = bus.result_valid;
      end
    end
  end

  int hw[6] = '{1950, 1900, 1901, 1100, 1099, 1};
  int hc[6] = '{2, 1, 2, 1, 0, 0};
  int rr[5] = '{0, 2, 5, 7, 0};

  initial begin
    bus.ena       = 1'b0;
    bus.pwm_in    = 8'h00;
    bus.ch_enable = 8'h00;
    #1;
    chk_reset_outs("rst0");
    repeat (3) tick();
    rst = 1'b0;
    repeat (2) tick();

    // Round robin across 0,2,5,7 starting from reset last_ch=7.
    bus.ch_enable = 8'hA5;
    bus.ena = 1'b1;
    repeat (10) tick();
    for (int i = 0; i < 5; i++) begin
      expect_res(rr[i], 1500, 1);
      pulse(8'hFF, 1500, 50);
    end
    drain(20);
    go_idle();

    // Channel 0 widths and thresholds; first pulse clears ch_enable.
    bus.ch_enable = 8'h01;
    bus.ena = 1'b1;
    repeat (10) tick();
    expect_res(0, hw[0], hc[0]);
    bus.pwm_in = 8'h01;
    repeat (900) tick();
    bus.ch_enable = 8'h00;
    repeat (1050) tick();
    bus.pwm_in = 8'h00;
    repeat (20) tick();
    bus.ch_enable = 8'h01;
    repeat (30) tick();
    for (int i = 1; i < 6; i++) begin
      expect_res(0, hw[i], hc[i]);
      pulse(8'h01, hw[i], 50);
    end
    drain(20);
    go_idle();

    // Stuck high then stuck low on channel 3.
    bus.ch_enable = 8'h08;
    bus.pwm_in = 8'h08;
    repeat (5) tick();
    bus.ena = 1'b1;
    expect_res(3, 2000, 3);
    drain(4010);
    go_idle();
    bus.pwm_in = 8'h00;
    repeat (5) tick();
    bus.ena = 1'b1;
    expect_res(3, 2000, 3);
    drain(4010);
    go_idle();

    // ena drop mid-measure; last_ch=3 so channel 4 both times.
    bus.ch_enable = 8'h50;
    bus.ena = 1'b1;
    repeat (10) tick();
    bus.pwm_in = 8'hFF;
    repeat (700) tick();
    chk("busy_measure", int'(bus.busy), 1);
    bus.ena = 1'b0;
    tick();
    chk("busy_drop", int'(bus.busy), 0);
    repeat (799) tick();
    bus.pwm_in = 8'h00;
    repeat (10) tick();
    bus.ena = 1'b1;
    repeat (10) tick();
    expect_res(4, 1500, 1);
    pulse(8'hFF, 1500, 50);
    drain(20);
    go_idle();

    // Async reset mid-measure, then lowest enabled channel first.
    bus.ch_enable = 8'hFF;
    bus.ena = 1'b1;
    repeat (10) tick();
    bus.pwm_in = 8'hFF;
    repeat (500) tick();
    #3 rst = 1'b1;
    #1;
    chk_reset_outs("rst_mid");
    repeat (2) tick();
    bus.pwm_in = 8'h00;
    bus.ch_enable = 8'h30;
    rst = 1'b0;
    repeat (10) tick();
    expect_res(4, 1500, 1);
    pulse(8'hFF, 1500, 50);
    drain(20);
    go_idle();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
